// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_mem,
  output logic              stall_if
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {IDLE, D_ACC, D_DONE, I_ACC, I_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_d_q, last_d_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_data_q, if_data_d, d_rdata_q, d_rdata_d;
  logic dreq, acc, done;
  assign dreq = d_rd | d_wr;
  assign acc = state_q == D_ACC || state_q == I_ACC;
  assign done = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d_d = last_d_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (dreq && !(if_req && last_d_q)) begin
          state_d = D_ACC;
          cnt_d = CW'(MEM_LAT - 1);
          wr_d = d_wr;
          addr_d = d_addr;
          wdata_d = d_wdata;
        end else if (if_req) begin
          state_d = I_ACC;
          cnt_d = CW'(MEM_LAT - 1);
          wr_d = 1'b0;
          addr_d = if_addr;
        end
      end
      D_ACC, I_ACC: begin
        cnt_d = done ? cnt_q : cnt_q - 1'b1;
        if (done) begin
          state_d = state_q == D_ACC ? D_DONE : I_DONE;
          d_rdata_d = state_q == D_ACC && !wr_q ? mem_rdata : d_rdata_q;
          if_data_d = state_q == I_ACC ? mem_rdata : if_data_q;
        end
      end
      D_DONE, I_DONE: begin
        state_d = IDLE;
        last_d_d = state_q == D_DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_d_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_d_q <= last_d_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign mem_en = acc;
  assign mem_wr = acc & wr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready = state_q == I_DONE;
  assign d_ready = state_q == D_DONE;
  assign if_data = if_data_q;
  assign d_rdata = d_rdata_q;
  assign stall_mem = ~rst & dreq & ~d_ready;
  assign stall_if = ~rst & ((if_req & ~if_ready) | stall_mem);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, stalls and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst, if_req, if_ready, d_rd, d_wr, d_ready, mem_en, mem_wr, stall_mem, stall_if;
  logic [15:0] if_addr, if_data, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_mem(stall_mem), .stall_if(stall_if)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    settle();
    chk("rst_mem_en", 16'(mem_en), 16'h0);
    chk("rst_if_ready", 16'(if_ready), 16'h0);
    chk("rst_d_ready", 16'(d_ready), 16'h0);
    chk("rst_if_data", if_data, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    chk("rst_stall_if", 16'(stall_if), 16'h0);
    chk("rst_stall_mem", 16'(stall_mem), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    settle();
    chk("post_rst_mem_en", 16'(mem_en), 16'h0);
    chk("post_rst_ready", 16'({if_ready, d_ready}), 16'h0);
    // fetch alone
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hA5A5;
    settle();
    chk("t1_c0_stall_if", 16'(stall_if), 16'h1);
    chk("t1_c0_mem_en", 16'(mem_en), 16'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t1_mem_en", 16'(mem_en), 16'h1);
      chk("t1_mem_addr", mem_addr, 16'h0010);
      chk("t1_mem_wr", 16'(mem_wr), 16'h0);
      chk("t1_stall_if", 16'(stall_if), 16'h1);
      chk("t1_if_ready_early", 16'(if_ready), 16'h0);
    end
    tick();
    chk("t1_if_ready", 16'(if_ready), 16'h1);
    chk("t1_if_data", if_data, 16'hA5A5);
    chk("t1_stall_if_c5", 16'(stall_if), 16'h0);
    chk("t1_mem_en_c5", 16'(mem_en), 16'h0);
    if_req = 1'b0;
    tick();
    chk("t1_c6_if_ready", 16'(if_ready), 16'h0);
    // simultaneous fetch + load, data wins
    if_req = 1'b1; if_addr = 16'h0040; d_rd = 1'b1; d_addr = 16'h0200; mem_rdata = 16'h1234;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t2_d_addr", mem_addr, 16'h0200);
      chk("t2_stall_mem", 16'(stall_mem), 16'h1);
    end
    tick();
    chk("t2_d_ready", 16'(d_ready), 16'h1);
    chk("t2_d_rdata", d_rdata, 16'h1234);
    chk("t2_if_ready_c5", 16'(if_ready), 16'h0);
    chk("t2_if_data_kept", if_data, 16'hA5A5);
    d_rd = 1'b0;
    tick();
    mem_rdata = 16'h5678;
    settle();
    chk("t2_c6_mem_en", 16'(mem_en), 16'h0);
    chk("t2_c6_stall_if", 16'(stall_if), 16'h1);
    for (int c = 7; c <= 10; c++) begin
      tick();
      chk("t2_i_mem_en", 16'(mem_en), 16'h1);
      chk("t2_i_addr", mem_addr, 16'h0040);
    end
    tick();
    chk("t2_if_ready", 16'(if_ready), 16'h1);
    chk("t2_if_data", if_data, 16'h5678);
    chk("t2_d_rdata_kept", d_rdata, 16'h1234);
    if_req = 1'b0;
    tick();
    // held load + fetch alternate D,I,D,I
    if_req = 1'b1; if_addr = 16'h0060; d_rd = 1'b1; d_addr = 16'h0500; mem_rdata = 16'h0BAD;
    for (int c = 1; c <= 23; c++) begin
      tick();
      chk("t3_mem_en", 16'(mem_en), 16'(c % 6 >= 1 && c % 6 <= 4));
      chk("t3_d_ready", 16'(d_ready), 16'(c == 5 || c == 17));
      chk("t3_if_ready", 16'(if_ready), 16'(c == 11 || c == 23));
      if (c % 6 >= 1 && c % 6 <= 4)
        chk("t3_mem_addr", mem_addr, (c / 6) % 2 == 0 ? 16'h0500 : 16'h0060);
    end
    chk("t3_d_rdata", d_rdata, 16'h0BAD);
    chk("t3_if_data", if_data, 16'h0BAD);
    if_req = 1'b0; d_rd = 1'b0;
    tick();
    // store, inputs changed after grant
    d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF; mem_rdata = 16'h7777;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        d_addr = 16'hFFFF; d_wdata = 16'h0000;
        settle();
      end
      chk("t4_mem_en", 16'(mem_en), 16'h1);
      chk("t4_mem_wr", 16'(mem_wr), 16'h1);
      chk("t4_mem_addr", mem_addr, 16'h0300);
      chk("t4_mem_wdata", mem_wdata, 16'hBEEF);
    end
    tick();
    chk("t4_d_ready", 16'(d_ready), 16'h1);
    chk("t4_d_rdata_kept", d_rdata, 16'h0BAD);
    chk("t4_mem_wr_c5", 16'(mem_wr), 16'h0);
    d_wr = 1'b0;
    tick();
    // load dropped mid-access still completes
    d_rd = 1'b1; d_addr = 16'h0400; mem_rdata = 16'h4444;
    settle();
    chk("t5_c0_stall_mem", 16'(stall_mem), 16'h1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        d_rd = 1'b0;
        settle();
      end
      chk("t5_mem_en", 16'(mem_en), 16'h1);
      chk("t5_stall_mem", 16'(stall_mem), 16'(c < 2));
    end
    tick();
    chk("t5_d_ready", 16'(d_ready), 16'h1);
    chk("t5_d_rdata", d_rdata, 16'h4444);
    chk("t5_stall_mem_c5", 16'(stall_mem), 16'h0);
    tick();
    // reset in the middle of a fetch
    if_req = 1'b1; if_addr = 16'h0080; mem_rdata = 16'h9999;
    tick();
    chk("t6_c1_mem_en", 16'(mem_en), 16'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_c3_mem_en", 16'(mem_en), 16'h0);
    chk("t6_c3_ready", 16'({if_ready, d_ready}), 16'h0);
    chk("t6_c3_if_data", if_data, 16'h0);
    chk("t6_c3_d_rdata", d_rdata, 16'h0);
    for (int c = 4; c <= 7; c++) begin
      tick();
      chk("t6_mem_en", 16'(mem_en), 16'h1);
      chk("t6_mem_addr", mem_addr, 16'h0080);
      chk("t6_no_ready", 16'(if_ready), 16'h0);
    end
    tick();
    chk("t6_if_ready", 16'(if_ready), 16'h1);
    chk("t6_if_data", if_data, 16'h9999);
    if_req = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
